// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, FSM state encoding and baud divisor helper.
// Used by uart_tx and by the companion uart_rx.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side byte stream plus line/status signals of the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 ready;
  logic                 busy;
  logic                 tx;

  modport master (output data, output data_valid, input ready, input busy, input tx);
  modport slave  (input data, input data_valid, output ready, output busy, output tx);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; pop is read-first (dout valid while not empty).
// Pushes while full and pops while empty are ignored; reset is synchronous, active low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             push_s;
  logic             pop_s;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; anything pushed during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, idle-high line, fed from an internal byte FIFO.
// Back-to-back bytes are sent with no gap between stop and next start bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ = 25_175_000,
  parameter int BAUD_RATE        = 9600,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQUENCY_HZ, BAUD_RATE);
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q;
  logic [CNT_W-1:0]     baud_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tx_q;

  logic [DATA_BITS-1:0] fifo_dout_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 baud_wrap_s;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .din_i   (bus.data),
    .pop_i   (pop_s),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign push_s   = bus.data_valid && !fifo_full_s;
  assign bus.ready = !fifo_full_s;
  assign bus.busy  = (state_q != ST_IDLE) || !fifo_empty_s;
  assign bus.tx    = tx_q;

  // Pop decision: a new byte is taken when idle or exactly as a stop bit ends.
  always_comb begin
    baud_wrap_s = (baud_q == CNT_LAST);
    pop_s       = 1'b0;
    case (state_q)
      ST_IDLE: pop_s = !fifo_empty_s;
      ST_STOP: pop_s = baud_wrap_s && !fifo_empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Frame sequencer; tx is updated together with each state change so it stays aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      baud_q    <= {CNT_W{1'b0}};
      bit_idx_q <= {IDX_W{1'b0}};
      shift_q   <= {DATA_BITS{1'b0}};
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          baud_q <= {CNT_W{1'b0}};
          tx_q   <= 1'b1;
          if (pop_s) begin
            shift_q <= fifo_dout_s;
            state_q <= ST_START;
            tx_q    <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_wrap_s) begin
            baud_q    <= {CNT_W{1'b0}};
            bit_idx_q <= {IDX_W{1'b0}};
            state_q   <= ST_DATA;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_wrap_s) begin
            baud_q <= {CNT_W{1'b0}};
            if (bit_idx_q == IDX_LAST) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
              bit_idx_q <= bit_idx_q + IDX_W'(1);
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (baud_wrap_s) begin
            baud_q <= {CNT_W{1'b0}};
            if (pop_s) begin
              shift_q <= fifo_dout_s;
              state_q <= ST_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level line model, ideal serial receiver and directed/random stimulus.
module tb_uart_tx;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  uart_tx_if bus ();

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_FREQUENCY_HZ (1600),
    .BAUD_RATE        (100),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Line model: FIFO contents as a queue, frame as an active flag plus cycle position.
  logic [7:0] m_q[$];
  logic [7:0] exp_rx[$];
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_push;
  bit         started = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      if (m_active) void'(exp_rx.pop_back());
      m_q.delete();
      m_active = 1'b0;
      m_pos = 0;
    end else begin
      m_push = bus.data_valid && (m_q.size() < DEPTH);
      if (!m_active) begin
        if (m_q.size() > 0) begin
          m_byte = m_q.pop_front();
          m_active = 1'b1;
          m_pos = 0;
          exp_rx.push_back(m_byte);
        end
      end else if (m_pos == FRAME - 1) begin
        if (m_q.size() > 0) begin
          m_byte = m_q.pop_front();
          m_pos = 0;
          exp_rx.push_back(m_byte);
        end else begin
          m_active = 1'b0;
        end
      end else begin
        m_pos++;
      end
      if (m_push) m_q.push_back(bus.data);
    end
    started = 1'b1;
  end

  function automatic logic model_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  always @(negedge clk) begin
    if (started) begin
      check("tx", 32'(bus.tx), 32'(model_tx()));
      check("busy", 32'(bus.busy), 32'(m_active || (m_q.size() > 0)));
      check("ready", 32'(bus.ready), 32'(m_q.size() < DEPTH));
    end
  end

  // Ideal receiver sampling mid-bit, compared against the bytes the model put on the line.
  bit         rx_on = 1'b0;
  int         rx_t = 0;
  int         rx_k;
  logic [7:0] rx_byte = 8'h00;
  int         rx_count = 0;
  logic [7:0] rx_last = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (bus.tx === 1'b0) begin
        rx_on = 1'b1;
        rx_t = 0;
      end
    end else begin
      rx_t++;
      if (rx_t == CPB / 2) begin
        check("rx_start", 32'(bus.tx), 32'd0);
      end else if (rx_t > CPB / 2 && ((rx_t - CPB / 2) % CPB) == 0) begin
        rx_k = (rx_t - CPB / 2) / CPB;
        if (rx_k <= 8) begin
          rx_byte[rx_k-1] = bus.tx;
        end else begin
          check("rx_stop", 32'(bus.tx), 32'd1);
          if (exp_rx.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rx_extra: got 0x%0h expected no byte at %0t", rx_byte, $time);
          end else begin
            check("rx_byte", 32'(rx_byte), 32'(exp_rx.pop_front()));
          end
          rx_last = rx_byte;
          rx_count++;
          rx_on = 1'b0;
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int w;
    bus.data = b;
    bus.data_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!bus.ready && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) check("push_timeout", 32'(bus.ready), 32'd1);
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    int base;
    int low;
    logic [9:0] pat;

    bus.data = 8'h00;
    bus.data_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_tx", 32'(bus.tx), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_ready", 32'(bus.ready), 32'd1);
    @(posedge clk);
    #1;

    // Single 0x55 frame: latency, mid-bit values, busy release.
    pat = 10'h2AA;
    push_byte(8'h55);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tx !== 1'b0 && n < 20);
    check("first_low_latency", 32'(n), 32'd2);
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? 8 : 16) @(negedge clk);
      check("frame55_bit", 32'(bus.tx), 32'(pat[k]));
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 400);
    check("busy_drop_55", 32'(n), 32'd8);
    check("rx_last_55", 32'(rx_last), 32'h55);
    @(posedge clk);
    #1;

    // Two bytes on consecutive cycles: contiguous 320-cycle busy window.
    base = rx_count;
    push_byte(8'hA3);
    push_byte(8'h0F);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 1000);
    check("busy_len_two", 32'(n), 32'd321);
    check("rx_two_count", 32'(rx_count - base), 32'd2);
    check("rx_last_0f", 32'(rx_last), 32'h0F);
    @(posedge clk);
    #1;

    // Fill the FIFO while a frame is in flight.
    base = rx_count;
    push_byte(8'($urandom));
    repeat (30) @(posedge clk);
    #1;
    cnt = 0;
    bus.data = 8'($urandom);
    bus.data_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.ready) break;
      @(posedge clk);
      #1;
      cnt++;
      bus.data = 8'($urandom);
    end
    check("accepts_before_full", 32'(cnt), 32'd16);
    n = 0;
    while (!bus.ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ready_returns", 32'(bus.ready), 32'd1);
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    wait_idle(5000);
    check("rx_fill_count", 32'(rx_count - base), 32'd18);

    // Reset during data bit 3 of 0xFF with more bytes queued.
    push_byte(8'hFF);
    push_byte(8'h11);
    push_byte(8'h22);
    n = 0;
    while (bus.tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (4 * CPB + 6) @(negedge clk);
    check("ff_data_bit3", 32'(bus.tx), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_tx", 32'(bus.tx), 32'd1);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_ready", 32'(bus.ready), 32'd1);
    @(posedge clk);
    #1;
    base = rx_count;
    push_byte(8'h12);
    wait_idle(1000);
    check("post_reset_count", 32'(rx_count - base), 32'd1);
    check("post_reset_byte", 32'(rx_last), 32'h12);

    // data_valid held throughout reset: nothing may be queued.
    base = rx_count;
    rst_n = 1'b0;
    bus.data_valid = 1'b1;
    repeat (20) begin
      bus.data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus.data_valid = 1'b0;
    rst_n = 1'b1;
    low = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) low++;
    end
    check("reset_push_tx_low", 32'(low), 32'd0);
    check("reset_push_busy", 32'(bus.busy), 32'd0);
    check("reset_push_count", 32'(rx_count - base), 32'd0);
    @(posedge clk);
    #1;

    // Random loopback traffic with random gaps.
    base = rx_count;
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 40)) @(posedge clk);
        #1;
      end
      push_byte(8'($urandom));
    end
    wait_idle(60000);
    check("loopback_count", 32'(rx_count - base), 32'd256);
    check("loopback_leftover", 32'(exp_rx.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
